// File: rtl/piso_sched_pkg.sv
// rtl/piso_sched_pkg.sv - shared types and width helpers for the PISO transmit scheduler
package piso_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} sched_state_t;

  function automatic int id_width(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

  function automatic int cnt_width(input int w, input int gap_cycles);
    return $clog2(((w > gap_cycles) ? w : gap_cycles) + 1);
  endfunction
endpackage

// File: rtl/piso_tx_scheduler_if.sv
// rtl/piso_tx_scheduler_if.sv - requester and PISO-side signal bundle of the scheduler
interface piso_tx_scheduler_if
  import piso_sched_pkg::*;
#(
  parameter int W       = 4,
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ*W-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_req_ack;
  logic                 o_piso_load;
  logic [W-1:0]         o_piso_data;
  logic                 o_bit_valid;
  logic                 o_frame_start;
  logic                 o_frame_end;
  logic [ID_W-1:0]      o_active_id;
  logic                 o_busy;

  modport master (
    output i_req, i_req_data,
    input  o_req_ack, o_piso_load, o_piso_data, o_bit_valid,
           o_frame_start, o_frame_end, o_active_id, o_busy
  );

  modport slave (
    input  i_req, i_req_data,
    output o_req_ack, o_piso_load, o_piso_data, o_bit_valid,
           o_frame_start, o_frame_end, o_active_id, o_busy
  );
endinterface

// File: rtl/piso_tx_scheduler_rr_arbiter.sv
// rtl/piso_tx_scheduler_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter
  import piso_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               valid
);
  logic [ID_W-1:0] idx;

  always_comb begin
    grant = '0;
    id    = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (en && !valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        id         = idx;
      end
    end
  end
endmodule

// File: rtl/piso_tx_scheduler.sv
// rtl/piso_tx_scheduler.sv - shares one PISO among requesters and marks the serial bits it emits
module piso_tx_scheduler
  import piso_sched_pkg::*;
#(
  parameter int W          = 4,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0
) (
  input logic                i_clk,
  input logic                i_rst,
  piso_tx_scheduler_if.slave bus
);
  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(W, GAP_CYCLES);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  sched_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, cur_id_q;
  logic               shift_last, gap_last;
  logic               arb_en, arb_valid;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_id;

  logic               load_q, load_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [W-1:0]       data_q, data_d;
  logic               valid_q, valid_d, start_q, start_d, end_q, end_d, busy_q, busy_d;
  logic [ID_W-1:0]    id_q, id_d;

  assign shift_last = (state_q == SHIFT) && (cnt_q == SHIFT_LAST);
  assign gap_last   = (state_q == GAP) && (cnt_q == GAP_LAST);
  assign arb_en     = (state_q == IDLE) || (shift_last && NO_GAP) || gap_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (bus.i_req),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (arb_grant),
    .id    (arb_id),
    .valid (arb_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A grant at an arbitration point overrides whatever the frame sequence would do next.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: ;
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        if (shift_last) begin
          state_d = NO_GAP ? IDLE : GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb_valid) begin
      state_d = LOAD;
      cnt_d   = '0;
    end
  end

  // Serial markers lag the SHIFT state by one register, matching the PISO output stage.
  always_comb begin
    load_d  = arb_valid;
    ack_d   = arb_grant;
    data_d  = arb_valid ? bus.i_req_data[int'(arb_id)*W +: W] : data_q;
    valid_d = (state_q == SHIFT);
    start_d = valid_d && (cnt_q == '0);
    end_d   = shift_last;
    id_d    = valid_d ? cur_id_q : '0;
    busy_d  = (state_d != IDLE) || valid_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q    <= '0;
      cur_id_q <= '0;
    end else if (arb_valid) begin
      ptr_q    <= (int'(arb_id) == NUM_REQ - 1) ? '0 : arb_id + 1'b1;
      cur_id_q <= arb_id;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      load_q  <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      load_q  <= load_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      start_q <= start_d;
      end_q   <= end_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_piso_load   = load_q;
  assign bus.o_req_ack     = ack_q;
  assign bus.o_piso_data   = data_q;
  assign bus.o_bit_valid   = valid_q;
  assign bus.o_frame_start = start_q;
  assign bus.o_frame_end   = end_q;
  assign bus.o_active_id   = id_q;
  assign bus.o_busy        = busy_q;
endmodule

// File: doc/piso_tx_scheduler.md
Name: piso_tx_scheduler

Overview:
Controller that shares one PISO serializer among several parallel-word requesters. It round-robin arbitrates requests, drives the PISO load strobe and parallel word, and counts the shift cycles. It also produces bit-valid and frame markers aligned to the PISO serial output, so downstream logic knows which requester owns each serial bit. It sits directly in front of the PISO; both blocks share clock and reset.

Parameters:
W, 4, word width; must equal the PISO width; W >= 2
NUM_REQ, 4, number of requesters; NUM_REQ >= 1
GAP_CYCLES, 0, extra idle cycles inserted after each frame before the next load

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high; also drives the PISO reset
i_req  in  NUM_REQ  per-requester request level; held high until the matching ack
i_req_data  in  NUM_REQ*W  per-requester word; slice k = [k*W +: W]; stable while i_req[k] is high
o_req_ack  out  NUM_REQ  one-hot, one-cycle pulse; word captured
o_piso_load  out  1  to the PISO load input
o_piso_data  out  W  to the PISO parallel input
o_bit_valid  out  1  PISO serial output carries a valid bit this cycle
o_frame_start  out  1  first (MSB) bit of a frame on the serial line
o_frame_end  out  1  last (LSB) bit of a frame on the serial line
o_active_id  out  clog2(max(NUM_REQ,2))  owner of the current serial bit; valid when o_bit_valid is high
o_busy  out  1  scheduler is not IDLE, or o_bit_valid is high

Behaviour:
- Reset (i_rst high at an edge): every output goes to 0, state goes to IDLE, RR pointer goes to 0, and the counters clear. Mid-frame reset aborts the frame with no ack or end marker. Outputs stay 0 on the first cycle after reset.
- States: IDLE, LOAD, SHIFT, GAP. All outputs are registered.
- Arbitration point: any IDLE cycle, the last SHIFT cycle when GAP_CYCLES = 0, or the last GAP cycle.
  - If any i_req bit is high, the winner is the first set bit searching upward from the RR pointer, with wrap-around.
  - At that edge: winner word goes to o_piso_data, o_piso_load = 1, o_req_ack[winner] = 1, RR pointer becomes (winner+1) mod NUM_REQ, and state moves to LOAD.
  - If no request is high, state moves to or stays in IDLE.
- Frame timing, with L = the cycle in which o_piso_load is high:
  - LOAD lasts 1 cycle.
  - SHIFT covers cycles L+1 .. L+W, with o_piso_load = 0.
  - GAP, if GAP_CYCLES > 0, covers L+W+1 .. L+W+GAP_CYCLES.
  - Earliest next load is L+W+1+GAP_CYCLES, so the frame period is W+1+GAP_CYCLES.
- PISO output alignment: bit W-1-k appears on the serial line in cycle L+2+k.
  - o_bit_valid is high for cycles L+2 .. L+W+1.
  - o_frame_start is high in L+2; o_frame_end is high in L+W+1.
  - o_active_id holds the winner over the same window. These signals are generated by a delay pipeline.
- Back-to-back frames, GAP = 0: the next load falls in L+W+1, which is the previous frame's o_frame_end cycle. The serial line holds the last bit through L+W+2, so o_bit_valid is low for exactly one cycle between frames.
- Ack rules:
  - A requester deasserts i_req the cycle after it sees its ack.
  - No re-arbitration occurs before the next arbitration point, so the old request cannot be granted twice.
  - A request that is still high at the next arbitration point is a new word.
- o_piso_data holds its value after LOAD; the PISO ignores it while shifting.
- i_req changes during SHIFT or GAP are ignored until the arbitration point.

Decomposition:
- Shared package `piso_sched_pkg`:
  - state enum {IDLE, LOAD, SHIFT, GAP}
  - id-width function clog2(max(n,2))
  - counter width derived from max(W, GAP_CYCLES)
- One sub-module `rr_arbiter` (NUM_REQ): inputs are the request vector, the pointer and an arbitration enable; outputs are a one-hot grant, the encoded id and a valid. It is combinational. The pointer register lives in the parent.

Test Plan:
- Single request: W=4, i_req[2] with data 4'b1011 -> o_piso_load in L; o_req_ack[2] in L; serial bits 1,0,1,1 at L+2..L+5; o_frame_start at L+2, o_frame_end at L+5; o_active_id = 2.
- Back-to-back: i_req[0] and i_req[1] high together, GAP=0 -> loads at L and L+5; o_bit_valid high for 4 cycles, low for 1, high for 4; ids 0 then 1.
- Round-robin fairness: all 4 requesters re-request continuously after their acks, for 8 frames -> grant order 0,1,2,3,0,1,2,3; no requester is acked twice per frame.
- GAP_CYCLES=2: continuous requests -> load-to-load spacing of exactly 7 cycles; o_busy stays high throughout.
- Reset mid-frame: assert i_rst in L+3 -> the next cycle has all outputs 0 and state IDLE. The next frame afterwards grants requester 0 first (pointer reset), and its bits align to the new L.
- Idle and late request: no requests for 10 cycles -> o_busy = 0 and no loads. A request raised during SHIFT is granted only at the arbitration point, with its load in L+W+1.
